// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RAM access modes, exception codes,
// FSM states and the request exception classifier.
package lsu_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_ADEL = 2'b01;
    localparam logic [1:0] EXC_ADES = 2'b10;
    localparam logic [1:0] EXC_BUS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Bus errors (illegal size, address beyond the RAM) outrank misalignment.
    function automatic logic [1:0] classify_exc(
        input logic       we,
        input logic [1:0] size,
        input logic [1:0] addr_lo,
        input logic       addr_oor
    );
        logic misaligned;
        misaligned = ((size == MODE_HALF) && addr_lo[0]) ||
                     ((size == MODE_WORD) && (addr_lo != 2'b00));
        if ((size == MODE_BAD) || addr_oor) begin
            return EXC_BUS;
        end else if (misaligned) begin
            return we ? EXC_ADES : EXC_ADEL;
        end
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the right-aligned RAM read data according to the
// load size and the unsigned flag.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] data
);

    always_comb begin
        case (size)
            MODE_BYTE: data = unsigned_ld ? {24'd0, rdata[7:0]}
                                          : {{24{rdata[7]}}, rdata[7:0]};
            MODE_HALF: data = unsigned_ld ? {16'd0, rdata[15:0]}
                                          : {{16{rdata[15]}}, rdata[15:0]};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: captures a request, checks it, performs
// one RAM access cycle and holds the response until the consumer takes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_mode,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_exc,
    output logic [15:0]       ld_count,
    output logic [15:0]       st_count
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        exc_q, exc_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [15:0]       ld_count_q, ld_count_d;
    logic [15:0]       st_count_q, st_count_d;

    logic        accept;
    logic        addr_oor;
    logic [1:0]  exc_chk;
    logic [31:0] load_data;

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign addr_oor = (req_addr >> ADDR_W) != 32'd0;
    assign exc_chk  = classify_exc(req_we, req_op[1:0], req_addr[1:0], addr_oor);

    lsu_load_ext u_load_ext (
        .rdata       (ram_rdata),
        .size        (op_q[1:0]),
        .unsigned_ld (op_q[2]),
        .data        (load_data)
    );

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; an async clr reaches state_q without waiting for clk.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            op_q       <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            exc_q      <= EXC_NONE;
            rsp_data_q <= 32'd0;
            ld_count_q <= 16'd0;
            st_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            exc_q      <= exc_d;
            rsp_data_q <= rsp_data_d;
            ld_count_q <= ld_count_d;
            st_count_q <= st_count_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = (exc_chk == EXC_NONE) ? ST_ACCESS : ST_RESP;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        exc_d      = exc_q;
        rsp_data_d = rsp_data_q;
        ld_count_d = ld_count_q;
        st_count_d = st_count_q;
        if (accept) begin
            we_d       = req_we;
            op_d       = req_op;
            addr_d     = req_addr[ADDR_W-1:0];
            wdata_d    = req_wdata;
            exc_d      = exc_chk;
            rsp_data_d = 32'd0;
        end
        if (state_q == ST_ACCESS) begin
            rsp_data_d = we_q ? 32'd0 : load_data;
        end
        // Counters advance only on a clean response handshake; wrap is natural.
        if ((state_q == ST_RESP) && rsp_ready && (exc_q == EXC_NONE)) begin
            if (we_q) st_count_d = st_count_q + 16'd1;
            else      ld_count_d = ld_count_q + 16'd1;
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) && !clr;
        ram_we    = (state_q == ST_ACCESS) && we_q;
        rsp_valid = (state_q == ST_RESP);
        ram_addr  = addr_q;
        ram_mode  = op_q[1:0];
        ram_wdata = wdata_q;
        rsp_data  = rsp_data_q;
        rsp_exc   = exc_q;
        ld_count  = ld_count_q;
        st_count  = st_count_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-lane RAM model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [11:0] ram_addr;
    logic [1:0]  ram_mode;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_exc;
    logic [15:0] ld_count;
    logic [15:0] st_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(12)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ram_addr  (ram_addr),
        .ram_mode  (ram_mode),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_exc   (rsp_exc),
        .ld_count  (ld_count),
        .st_count  (st_count)
    );

    // RAM model: combinational read, lane-shifted to bit 0 and zero-extended.
    always_comb begin
        logic [31:0] word;
        word      = mem[ram_addr[11:2]] >> (8 * ram_addr[1:0]);
        ram_rdata = word;
        case (ram_mode)
            2'b00:   ram_rdata = {24'd0, word[7:0]};
            2'b01:   ram_rdata = {16'd0, word[15:0]};
            default: ram_rdata = word;
        endcase
    end

    always @(posedge clk) begin
        if (ram_we) begin
            case (ram_mode)
                2'b00: mem[ram_addr[11:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[7:0];
                2'b01: mem[ram_addr[11:2]][8*ram_addr[1:0] +: 16] <= ram_wdata[15:0];
                default: mem[ram_addr[11:2]] <= ram_wdata;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the capturing edge.
    task automatic issue(input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0] = 32'h8000_0000;
        mem[1] = 32'hCAFE_F00D;
        mem[2] = 32'h5555_AAAA;

        clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_counts", {ld_count, st_count}, 32'd0);
        check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
        clr = 1'b0;
        #1;
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // LB 0x003: byte 0x80 sign-extends
        issue(1'b0, 3'b000, 32'h003, 32'd0);
        check("lb_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("lb_access_addr", {20'd0, ram_addr}, 32'h003);
        check("lb_access_we", {31'd0, ram_we}, 32'd0);
        step();
        check("lb_n2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("lb_data", rsp_data, 32'hFFFF_FF80);
        check("lb_exc", {30'd0, rsp_exc}, 32'd0);
        check("lb_resp_req_ready", {31'd0, req_ready}, 32'd0);
        handshake();
        check("lb_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("lb_ld_count", {16'd0, ld_count}, 32'd1);

        // LBU same address: zero-extended
        issue(1'b0, 3'b100, 32'h003, 32'd0);
        step();
        check("lbu_data", rsp_data, 32'h0000_0080);
        handshake();
        check("lbu_ld_count", {16'd0, ld_count}, 32'd2);

        // SH 0x1234ABCD at 0x006
        issue(1'b1, 3'b001, 32'h006, 32'h1234_ABCD);
        check("sh_ram_we", {31'd0, ram_we}, 32'd1);
        check("sh_ram_mode", {30'd0, ram_mode}, 32'd1);
        check("sh_ram_addr", {20'd0, ram_addr}, 32'h006);
        check("sh_ram_wdata", ram_wdata, 32'h1234_ABCD);
        step();
        check("sh_resp_we", {31'd0, ram_we}, 32'd0);
        check("sh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("sh_rsp_data", rsp_data, 32'd0);
        handshake();
        check("sh_st_count", {16'd0, st_count}, 32'd1);
        check("sh_wdata_hold", ram_wdata, 32'h1234_ABCD);

        // Read back the stored half: 0x004 now holds 0xABCDF00D
        issue(1'b0, 3'b001, 32'h006, 32'd0);
        step();
        check("lh_data", rsp_data, 32'hFFFF_ABCD);
        handshake();
        issue(1'b0, 3'b010, 32'h004, 32'd0);
        step();
        check("lw_data", rsp_data, 32'hABCD_F00D);
        handshake();
        check("lw_ld_count", {16'd0, ld_count}, 32'd4);

        // Exceptions respond one cycle after capture, with no RAM write
        issue(1'b0, 3'b010, 32'h002, 32'd0);
        check("adel_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("adel_exc", {30'd0, rsp_exc}, 32'd1);
        check("adel_ram_we", {31'd0, ram_we}, 32'd0);
        check("adel_data", rsp_data, 32'd0);
        handshake();
        check("adel_ld_count", {16'd0, ld_count}, 32'd4);

        issue(1'b1, 3'b011, 32'h401, 32'hDEAD_BEEF);
        check("bus_exc", {30'd0, rsp_exc}, 32'd3);
        check("bus_ram_we", {31'd0, ram_we}, 32'd0);
        handshake();
        check("bus_st_count", {16'd0, st_count}, 32'd1);

        issue(1'b1, 3'b010, 32'h006, 32'hDEAD_BEEF);
        check("ades_exc", {30'd0, rsp_exc}, 32'd2);
        check("ades_ram_we", {31'd0, ram_we}, 32'd0);
        handshake();

        issue(1'b0, 3'b000, 32'h1000, 32'd0);
        check("oor_exc", {30'd0, rsp_exc}, 32'd3);
        handshake();
        check("exc_counts", {ld_count, st_count}, {16'd4, 16'd1});

        // Back-pressure: response held 5 cycles while a new request waits
        issue(1'b0, 3'b010, 32'h004, 32'd0);
        step();
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h003;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'hABCD_F00D);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        handshake();
        check("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0; req_addr = 32'd0;
        check("bp_next_accepted", {31'd0, req_ready}, 32'd0);
        check("bp_next_addr", {20'd0, ram_addr}, 32'h003);
        step();
        check("bp_next_data", rsp_data, 32'hFFFF_FF80);
        handshake();
        check("bp_ld_count", {16'd0, ld_count}, 32'd6);

        // clr mid-ACCESS of a store aborts the write immediately
        issue(1'b1, 3'b010, 32'h008, 32'h1111_1111);
        check("abort_pre_we", {31'd0, ram_we}, 32'd1);
        #2;
        clr = 1'b1;
        #1;
        check("abort_ram_we", {31'd0, ram_we}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd0);
        check("abort_wdata", ram_wdata, 32'd0);
        check("abort_counts", {ld_count, st_count}, 32'd0);
        step();
        clr = 1'b0;
        #1;
        check("abort_rel_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        issue(1'b0, 3'b010, 32'h008, 32'd0);
        step();
        check("abort_readback", rsp_data, 32'h5555_AAAA);
        handshake();
        check("abort_ld_count", {16'd0, ld_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
